apb_requester: RTL and testbench
================================

# apb_requester

APB requester (manager) that converts a simple valid/ready command stream into APB SETUP/ACCESS transfers toward `apb_peripheral` and returns one response per command. It sits between on-chip control logic or the testbench sequencer and the APB bus. It supports wait states, back-to-back chained transfers, and PSLVERR capture, with an optional wait-state timeout.

## Interface
- ADDR_WIDTH, apb_pkg::ADDR_WIDTH: PADDR / cmd_addr width.
- DATA_WIDTH, 32: PWDATA / PRDATA width.
- TIMEOUT, 16: maximum consecutive wait-state cycles. Must be ≥1. Used only with APB_REQ_TIMEOUT_EN.
- pclk  in  1  clock.
- preset  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a pclk edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target byte address. Forwarded unchanged, including misaligned addresses.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle response pulse. No backpressure.
- rsp_rdata  out  DATA_WIDTH  read data. 0 for writes and errors.
- rsp_err  out  1  PSLVERR or timeout.
- psel, penable, pwrite  out  1 each  APB controls.
- paddr  out  ADDR_WIDTH; pwdata  out  DATA_WIDTH  APB address/data.
- pready, pslverr  in  1 each; prdata  in  DATA_WIDTH  APB completer response.

## Operation
- FSM uses apb_pkg::state: IDLE, SETUP, ACCESS.
- **IDLE**
  - psel=0, penable=0.
  - On command accept, register write/addr/wdata and go to SETUP.
- **SETUP**
  - psel=1, penable=0; registered command fields driven.
  - Unconditionally go to ACCESS.
- **ACCESS**
  - psel=1, penable=1; fields held stable.
  - pready=0: stay in ACCESS (wait state).
  - pready=1: transfer completes.
    - Next cycle: rsp_valid=1, rsp_err=pslverr. rsp_rdata=prdata on an error-free read, else 0.
    - If a command is accepted in the same cycle, go to SETUP with psel held high (chained).
    - Otherwise go to IDLE.
- cmd_ready is combinational:
  - 1 when (state==IDLE) || (state==ACCESS && pready), and preset=0.
  - Forced 0 while preset=1.
- pwdata=0 on reads. paddr/pwrite/pwdata keep their last values in IDLE.
- Misaligned addresses are not checked locally. The completer's PSLVERR is reported through rsp_err.
- Reset mid-transfer: all outputs are cleared immediately, FSM goes to IDLE, the in-flight command is dropped, and no response is emitted.

## Timing
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Accept at edge N → SETUP in cycle N+1 → ACCESS in N+2.
  - Zero wait states: pready sampled at the end of N+2, rsp_valid in N+3.
  - Minimum latency is 3 cycles. Each wait state adds 1.
- Chained throughput: one transfer per 2 cycles (SETUP, ACCESS).
- rsp_valid is high for exactly one cycle per completed or timed-out transfer.

## Configuration
- Macro APB_REQ_TIMEOUT_EN.
- **Defined:**
  - A counter clears on entering ACCESS and increments on each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT, the transfer is aborted:
    - Next cycle: psel=0, penable=0, FSM to IDLE.
    - Same cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
    - cmd_ready stays 0 during the abort cycle, so no chaining after a timeout.
- **Undefined:** no counter. The requester waits indefinitely in ACCESS.

## Structure
- apb_pkg holds: the state enum (IDLE/SETUP/ACCESS), ADDR_WIDTH, ALIGNBITS, validAlign.
- Add to apb_pkg: apb_cmd_t struct (write, addr, wdata) and apb_rsp_t struct (rdata, err).
- One sub-module, apb_req_timeout: wait-state counter with clear/inc/expired, instantiated only under APB_REQ_TIMEOUT_EN.

## Test plan
- Write addr 0x8, data 0xDEADBEEF, pready tied 1 → SETUP then ACCESS with pwrite=1, pwdata=0xDEADBEEF; rsp_valid in cycle 3, rsp_err=0.
- Read 0x8 after that write, via apb_peripheral → rsp_rdata=0xDEADBEEF, rsp_err=0.
- Two reads with cmd_valid held high → psel stays 1 across both transfers; penable pattern 0,1,0,1; two rsp_valid pulses 2 cycles apart.
- Read addr 0x6 (misaligned) → completer asserts pslverr; rsp_err=1, rsp_rdata=0.
- pready held 0 for 3 cycles → ACCESS lasts 4 cycles, fields stable throughout; rsp_valid at cycle 6.
- With APB_REQ_TIMEOUT_EN and TIMEOUT=4, pready tied 0 → abort after 4 wait cycles; rsp_err=1; psel=0 next cycle.
- Assert preset while in ACCESS → psel/penable drop immediately; no rsp_valid pulse; next command after reset behaves normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester: FSM state encoding,
// bus widths, command/response structs and an address-alignment helper.
package apb_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int ALIGNBITS  = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state;

   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } apb_cmd_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] rdata;
      logic                  err;
   } apb_rsp_t;

   // True when the byte address is word aligned.
   function automatic logic validAlign(input logic [ADDR_WIDTH-1:0] addr);
      return (addr[ALIGNBITS-1:0] == '0);
   endfunction

endpackage

// File: rtl/apb_requester_if.sv
// Command/response stream plus APB bus signals of the requester, grouped with
// master (requester side) and slave (sequencer + completer side) modports.
interface apb_requester_if #(
   parameter int ADDR_WIDTH = apb_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = apb_pkg::DATA_WIDTH
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic                  pready;
   logic                  pslverr;
   logic [DATA_WIDTH-1:0] prdata;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, pslverr, prdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
             psel, penable, pwrite, paddr, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, pslverr, prdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
             psel, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/apb_req_timeout.sv
// Wait-state counter for the APB requester: cleared before each ACCESS phase,
// counts stalled ACCESS cycles and saturates at TIMEOUT (o_expired).
module apb_req_timeout #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_inc,
   output logic o_expired
);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_count <= '0;
      else if (i_clear)
         r_count <= '0;
      else if (i_inc && !o_expired)
         r_count <= r_count + 1'b1;
   end

   assign o_expired = (r_count == CW'(TIMEOUT));
endmodule

// File: rtl/apb_requester.sv
// APB requester: turns a valid/ready command stream into SETUP/ACCESS transfers
// and returns one response per command. APB_REQ_TIMEOUT_EN adds a wait-state abort.
//
// state  | meaning
// IDLE   | bus idle, command accepted here
// SETUP  | psel=1, penable=0, registered command on the bus
// ACCESS | psel=1, penable=1, waiting for pready (or timeout)
module apb_requester #(
   parameter int ADDR_WIDTH = apb_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input logic            pclk,
   input logic            preset,
   apb_requester_if.master bus
);
   import apb_pkg::*;

   state                  r_state;
   state                  w_next;
   logic                  r_pwrite;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic                  r_rsp_valid;
   logic                  r_rsp_err;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  w_cmd_ready;
   logic                  w_accept;
   logic                  w_done;
   logic                  w_abort;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("apb_requester: TIMEOUT must be >= 1");
   end

`ifdef APB_REQ_TIMEOUT_EN
   logic w_expired;

   apb_req_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk       (pclk),
      .rst       (preset),
      .i_clear   (r_state == SETUP),
      .i_inc     ((r_state == ACCESS) && !bus.pready),
      .o_expired (w_expired)
   );

   // Expiry wins over a late pready in the same cycle: the response is already the abort.
   assign w_abort = (r_state == ACCESS) && w_expired;
`else
   assign w_abort = 1'b0;
`endif

   assign w_cmd_ready = !preset &&
                        ((r_state == IDLE) ||
                         ((r_state == ACCESS) && bus.pready && !w_abort));
   assign w_accept    = bus.cmd_valid && w_cmd_ready;
   assign w_done      = (r_state == ACCESS) && bus.pready && !w_abort;

   always_ff @(posedge pclk or posedge preset) begin
      if (preset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = SETUP;
         SETUP:   w_next = ACCESS;
         ACCESS: begin
            if (w_abort)
               w_next = IDLE;
            else if (bus.pready)
               w_next = w_accept ? SETUP : IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_pwrite <= 1'b0;
         r_paddr  <= '0;
         r_pwdata <= '0;
      end else if (w_accept) begin
         r_pwrite <= bus.cmd_write;
         r_paddr  <= bus.cmd_addr;
         r_pwdata <= bus.cmd_write ? bus.cmd_wdata : '0;
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= w_done;
         r_rsp_err   <= w_done && bus.pslverr;
         r_rsp_rdata <= (w_done && !r_pwrite && !bus.pslverr) ? bus.prdata : '0;
      end
   end

   assign bus.cmd_ready = w_cmd_ready;
   assign bus.psel      = (r_state != IDLE);
   assign bus.penable   = (r_state == ACCESS);
   assign bus.pwrite    = r_pwrite;
   assign bus.paddr     = r_paddr;
   assign bus.pwdata    = r_pwdata;
   // r_rsp_* are zero during an abort cycle, so OR-ing in the abort is safe.
   assign bus.rsp_valid = r_rsp_valid | w_abort;
   assign bus.rsp_err   = r_rsp_err | w_abort;
   assign bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester with a small memory-backed APB completer
// (programmable wait states, stall, PSLVERR on misaligned addresses).
module tb_apb_requester;
   import apb_pkg::*;

   logic pclk   = 1'b0;
   logic preset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   tb_wait  = 0;
   logic tb_stall = 1'b0;
   int   wcnt     = 0;
   logic [31:0] mem [16];

   apb_requester_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
      .pclk   (pclk),
      .preset (preset),
      .bus    (bus.master)
   );

   always #5 pclk = ~pclk;

   always_comb begin
      bus.pready  = bus.penable && !tb_stall && (wcnt >= tb_wait);
      bus.pslverr = bus.psel && bus.penable && !validAlign(bus.paddr);
      bus.prdata  = mem[bus.paddr[5:2]];
   end

   always @(posedge pclk) begin
      if (bus.penable && !bus.pready) wcnt <= wcnt + 1;
      else                            wcnt <= 0;
      if (bus.psel && bus.penable && bus.pready && bus.pwrite && !bus.pslverr)
         mem[bus.paddr[5:2]] <= bus.pwdata;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   // Issues one command, returns once rsp_valid is seen (sitting in that cycle).
   task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int n_acc, output int n_bad);
      int g;
      lat = 0; n_acc = 0; n_bad = 0; rd = '0; er = 1'b0; g = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      while (!bus.cmd_ready && g < 50) begin
         step();
         g++;
      end
      check("accept_wait", 32'(g < 50), 32'd1);
      step();
      bus.cmd_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 60) begin
         if (bus.penable) n_acc++;
         if (bus.psel && (bus.paddr !== a || bus.pwrite !== w ||
                          bus.pwdata !== (w ? d : 32'h0)))
            n_bad++;
         step();
         lat++;
      end
      check("rsp_wait", 32'(lat < 60), 32'd1);
      rd = bus.rsp_rdata;
      er = bus.rsp_err;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, n_acc, n_bad;
      logic [31:0] rd, rd0, rd1;
      logic        er, rv_seen;
      logic [4:0]  ps, pe, rv;

      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      repeat (2) @(posedge pclk);
      #1;

      check("rst_psel",      32'(bus.psel),      32'd0);
      check("rst_penable",   32'(bus.penable),   32'd0);
      check("rst_pwrite",    32'(bus.pwrite),    32'd0);
      check("rst_paddr",     bus.paddr,          32'd0);
      check("rst_pwdata",    bus.pwdata,         32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
      check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      preset = 1'b0;
      #1;
      check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

      // Write 0x8 / 0xDEADBEEF, zero wait states, cycle by cycle
      step();
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h8;
      bus.cmd_wdata = 32'hDEADBEEF;
      check("wr_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      step();
      bus.cmd_valid = 1'b0;
      check("wr_setup_psel",    32'(bus.psel),    32'd1);
      check("wr_setup_penable", 32'(bus.penable), 32'd0);
      check("wr_setup_pwrite",  32'(bus.pwrite),  32'd1);
      check("wr_setup_paddr",   bus.paddr,        32'h8);
      check("wr_setup_pwdata",  bus.pwdata,       32'hDEADBEEF);
      check("wr_setup_ready",   32'(bus.cmd_ready), 32'd0);
      step();
      check("wr_acc_psel",    32'(bus.psel),    32'd1);
      check("wr_acc_penable", 32'(bus.penable), 32'd1);
      check("wr_acc_pwdata",  bus.pwdata,       32'hDEADBEEF);
      step();
      check("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("wr_rsp_err",   32'(bus.rsp_err),   32'd0);
      check("wr_rsp_rdata", bus.rsp_rdata,      32'd0);
      check("wr_rsp_psel",  32'(bus.psel),      32'd0);
      step();
      check("wr_rsp_pulse", 32'(bus.rsp_valid), 32'd0);

      // Read it back
      run_cmd(1'b0, 32'h8, 32'hFFFF_FFFF, lat, rd, er, n_acc, n_bad);
      check("rd_lat",   32'(lat), 32'd3);
      check("rd_rdata", rd,       32'hDEADBEEF);
      check("rd_err",   32'(er),  32'd0);
      step();
      check("rd_idle_pwdata", bus.pwdata,       32'd0);
      check("rd_idle_pwrite", 32'(bus.pwrite),  32'd0);
      check("rd_idle_paddr",  bus.paddr,        32'h8);

      run_cmd(1'b1, 32'hC, 32'h12345678, lat, rd, er, n_acc, n_bad);
      check("wr2_lat", 32'(lat), 32'd3);
      step();

      // Chained reads of 0x8 then 0xC with cmd_valid held high
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h8;
      step();
      ps = '0; pe = '0; rv = '0; rd0 = '0; rd1 = '0;
      for (int i = 0; i < 5; i++) begin
         ps = {ps[3:0], bus.psel};
         pe = {pe[3:0], bus.penable};
         rv = {rv[3:0], bus.rsp_valid};
         if (i == 2) rd0 = bus.rsp_rdata;
         if (i == 4) rd1 = bus.rsp_rdata;
         if (i == 0) bus.cmd_addr = 32'hC;
         if (i == 2) bus.cmd_valid = 1'b0;
         step();
      end
      check("chain_psel",    32'(ps), 32'b11110);
      check("chain_penable", 32'(pe), 32'b01010);
      check("chain_rsp",     32'(rv), 32'b00101);
      check("chain_rdata0",  rd0,     32'hDEADBEEF);
      check("chain_rdata1",  rd1,     32'h12345678);

      // Misaligned read reports the completer's error
      run_cmd(1'b0, 32'h6, 32'h0, lat, rd, er, n_acc, n_bad);
      check("mis_err",   32'(er), 32'd1);
      check("mis_rdata", rd,      32'd0);
      check("mis_lat",   32'(lat), 32'd3);
      step();

      // Three wait states
      tb_wait = 3;
      run_cmd(1'b1, 32'h10, 32'hA5A55A5A, lat, rd, er, n_acc, n_bad);
      check("ws3_lat",    32'(lat),   32'd6);
      check("ws3_access", 32'(n_acc), 32'd4);
      check("ws3_stable", 32'(n_bad), 32'd0);
      check("ws3_err",    32'(er),    32'd0);
      step();
      check("ws3_pulse", 32'(bus.rsp_valid), 32'd0);
      tb_wait = 1;
      run_cmd(1'b0, 32'h10, 32'h0, lat, rd, er, n_acc, n_bad);
      check("ws1_lat",   32'(lat), 32'd4);
      check("ws1_rdata", rd,       32'hA5A55A5A);
      tb_wait = 0;
      step();

`ifdef APB_REQ_TIMEOUT_EN
      tb_stall = 1'b1;
      run_cmd(1'b0, 32'h8, 32'h0, lat, rd, er, n_acc, n_bad);
      check("to_lat",    32'(lat),   32'd6);
      check("to_err",    32'(er),    32'd1);
      check("to_rdata",  rd,         32'd0);
      check("to_access", 32'(n_acc), 32'd4);
      check("to_ready",  32'(bus.cmd_ready), 32'd0);
      step();
      check("to_psel",   32'(bus.psel),      32'd0);
      check("to_pulse",  32'(bus.rsp_valid), 32'd0);
      tb_stall = 1'b0;
      step();
`endif

      // Reset while stalled in ACCESS drops the transfer
      tb_stall = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h8;
      bus.cmd_wdata = 32'h11112222;
      step();
      bus.cmd_valid = 1'b0;
      step();
      check("mr_penable", 32'(bus.penable), 32'd1);
      preset = 1'b1;
      #1;
      check("mr_psel",    32'(bus.psel),      32'd0);
      check("mr_penable0",32'(bus.penable),   32'd0);
      check("mr_ready",   32'(bus.cmd_ready), 32'd0);
      rv_seen = bus.rsp_valid;
      repeat (3) begin
         step();
         rv_seen = rv_seen | bus.rsp_valid;
      end
      tb_stall = 1'b0;
      preset   = 1'b0;
      step();
      rv_seen = rv_seen | bus.rsp_valid;
      check("mr_no_rsp", 32'(rv_seen), 32'd0);
      run_cmd(1'b0, 32'h8, 32'h0, lat, rd, er, n_acc, n_bad);
      check("mr_after_lat",   32'(lat), 32'd3);
      check("mr_after_rdata", rd,       32'hDEADBEEF);
      check("mr_after_err",   32'(er),  32'd0);
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
